mlp_patch_loader: RTL and testbench
===================================

Name: mlp_patch_loader

Overview:
- Upstream feeder for the mlp classifier.
- Accepts a serial stream of quantized event-patch samples, one per handshake: 4-bit magnitude plus polarity bit.
- Assembles them into the parallel in_mag/in_pol vectors the mlp consumes, waits the mlp latency, then captures the mlp output as a per-event score.
- Returns the score to the downstream event filter over a valid/ready interface, with framing-error detection on the input stream.

Parameters:
- N1, 98, mlp first-layer input count; patch holds P = N1/2 = 49 samples.
- W_X, 4, sample magnitude width.
- W_Y, 16, mlp output / score width.
- MLP_LAT, 0, register stages inside mlp between inputs and out (0 = purely combinational).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample ready
- s_mag  in  W_X  sample magnitude
- s_pol  in  1  sample polarity
- s_last  in  1  marks final sample of patch
- mlp_in_mag  out  [N1/2][W_X]  to mlp in_mag
- mlp_in_pol  out  [N1/2]  to mlp in_pol
- mlp_out  in  W_Y  from mlp out
- m_valid  out  1  score valid
- m_ready  in  1  score accepted downstream
- m_score  out  W_Y  captured mlp output
- m_err  out  1  one-cycle pulse: patch framing error, patch discarded

Behaviour:
- Reset (rst high at posedge):
  - state=LOAD, sample index idx=0, wait counter=0.
  - m_valid=0, m_score=0, m_err=0, mlp_in_mag=0, mlp_in_pol=0.
  - s_ready is 0 while rst is high and in the cycle it is sampled; it is 1 from the first cycle in LOAD after reset.
  - Reset in any state, including mid-patch or mid-wait, abandons all work with no m_valid and no m_err.
- Handshake: a transfer occurs on a posedge where valid&&ready. s_ready is combinational from state only (1 iff LOAD or DRAIN), never from s_valid.
- States:
  - LOAD: each accepted sample writes element idx (mlp_in_mag[idx]=s_mag, mlp_in_pol[idx]=s_pol), then idx++.
    - Accept with idx<P-1 and s_last=1 (short patch): m_err pulses next cycle, idx=0, stay LOAD.
    - Accept with idx=P-1 and s_last=1: go WAIT, wcnt=0.
    - Accept with idx=P-1 and s_last=0 (long patch): m_err pulses next cycle, go DRAIN.
  - DRAIN: s_ready=1; samples are discarded. On accepting a sample with s_last=1, idx=0 and go LOAD.
  - WAIT: s_ready=0; mlp_in_* held stable; wcnt increments each cycle. When wcnt==MLP_LAT: m_score<=mlp_out, m_valid<=1, go OUT.
  - OUT: s_ready=0; m_valid=1, m_score held. On m_valid&&m_ready: m_valid<=0, go LOAD, idx=0.
- Latency: with the final sample accepted at edge E, the score is captured at edge E+1+MLP_LAT, and m_valid is high from then until handshake. MLP_LAT=0 gives m_valid one cycle after the final accept.
- mlp_in_* change only on accepted LOAD samples. Elements not yet rewritten retain previous values; the discard path does not clear them.
- No overlap: the next patch is not accepted until the score handshake completes. Minimum patch period is P+2+MLP_LAT cycles with s_valid and m_ready held high.
- m_err never coincides with m_valid.
- s_mag/s_pol/s_last are ignored when no transfer occurs.

Test Plan:
- Full patch, MLP_LAT=0, mlp stub out = sum of in_mag: stream 49 samples with mag=k%16, pol=k%2, s_last on k=48 -> mlp_in_mag[k]==k%16; m_valid one cycle after the 49th accept; m_score==0x0168 (360).
- MLP_LAT=3 stub (3-stage delay of the sum), m_ready=0 for 10 cycles after m_valid -> m_valid rises 4 cycles after the final accept; m_score stable while stalled; s_ready=0 throughout; after m_ready=1, s_ready=1 the next cycle.
- Short patch (s_last on 20th sample) then a valid 49-sample patch -> single m_err pulse, no m_valid for the short patch, correct score for the second.
- Long patch (no s_last at 49; s_last on 55th) -> m_err pulse after the 49th accept, samples 50-55 dropped with s_ready=1, no m_valid; the next patch scores correctly.
- Random s_valid gaps (50% duty) on a full patch -> same score and mlp_in contents as the gap-free run.
- rst asserted for one cycle during WAIT and during OUT -> m_valid=0, m_score=0, mlp_in_*=0 next cycle; no m_err; a fresh patch after reset scores correctly.

Source files
------------

// File: rtl/mlp_patch_loader.sv
// rtl/mlp_patch_loader.sv - serial patch sample loader and score capture for the mlp classifier
module mlp_patch_loader #(
    parameter int N1      = 98,
    parameter int W_X     = 4,
    parameter int W_Y     = 16,
    parameter int MLP_LAT = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [W_X-1:0]                s_mag,
    input  logic                          s_pol,
    input  logic                          s_last,
    output logic [N1/2-1:0][W_X-1:0]      mlp_in_mag,
    output logic [N1/2-1:0]               mlp_in_pol,
    input  logic [W_Y-1:0]                mlp_out,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [W_Y-1:0]                m_score,
    output logic                          m_err
);

    localparam int P   = N1 / 2;
    localparam int IW  = (P > 1) ? $clog2(P) : 1;
    localparam int WCW = (MLP_LAT > 0) ? $clog2(MLP_LAT + 1) : 1;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                      state_q;
    logic [IW-1:0]               idx_q;
    logic [WCW-1:0]              wcnt_q;
    logic [P-1:0][W_X-1:0]       mag_q;
    logic [P-1:0]                pol_q;
    logic                        valid_q;
    logic [W_Y-1:0]              score_q;
    logic                        err_q;
    logic                        s_xfer;
    logic                        at_end;

    // Ready depends only on state (and reset), so upstream never sees a combinational loop through s_valid
    assign s_ready = !rst && ((state_q == LOAD) || (state_q == DRAIN));
    assign s_xfer  = s_valid && s_ready;
    assign at_end  = (idx_q == IW'(P - 1));

    assign mlp_in_mag = mag_q;
    assign mlp_in_pol = pol_q;
    assign m_valid    = valid_q;
    assign m_score    = score_q;
    assign m_err      = err_q;

    // Patch framing FSM: fill the parallel vector, wait out mlp latency, hold the score until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            wcnt_q  <= '0;
            mag_q   <= '0;
            pol_q   <= '0;
            valid_q <= 1'b0;
            score_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (s_xfer) begin
                        mag_q[idx_q] <= s_mag;
                        pol_q[idx_q] <= s_pol;
                        if (at_end) begin
                            idx_q <= '0;
                            if (s_last) begin
                                state_q <= WAIT;
                                wcnt_q  <= '0;
                            end else begin
                                // Too many samples: flag now, swallow the rest of the patch
                                err_q   <= 1'b1;
                                state_q <= DRAIN;
                            end
                        end else if (s_last) begin
                            // Patch ended early: discard and restart at element 0
                            err_q <= 1'b1;
                            idx_q <= '0;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (s_xfer && s_last) begin
                        idx_q   <= '0;
                        state_q <= LOAD;
                    end
                end
                WAIT: begin
                    if (wcnt_q == WCW'(MLP_LAT)) begin
                        score_q <= mlp_out;
                        valid_q <= 1'b1;
                        state_q <= OUT;
                    end else begin
                        wcnt_q <= wcnt_q + WCW'(1);
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        valid_q <= 1'b0;
                        idx_q   <= '0;
                        state_q <= LOAD;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_patch_loader.sv
// tb/tb_mlp_patch_loader.sv - randomized directed bench for mlp_patch_loader (MLP_LAT 0 and 3)
module tb_mlp_patch_loader;

    localparam int P = 49;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // index 0: MLP_LAT=0 instance, index 1: MLP_LAT=3 instance
    logic                 rst[2];
    logic                 s_valid[2];
    logic [3:0]           s_mag[2];
    logic                 s_pol[2];
    logic                 s_last[2];
    logic                 m_ready[2];

    logic                 s_ready[2];
    logic                 m_valid[2];
    logic                 m_err[2];
    logic [15:0]          m_score[2];
    logic [P-1:0][3:0]    mlp_mag[2];
    logic [P-1:0]         mlp_pol[2];

    logic                 s_ready0, s_ready1, m_valid0, m_valid1, m_err0, m_err1;
    logic [15:0]          m_score0, m_score1, mlp_out0, mlp_out1;
    logic [P-1:0][3:0]    mag0, mag1;
    logic [P-1:0]         pol0, pol1;
    logic [15:0]          pipe1, pipe2, pipe3;

    function automatic logic [15:0] sum_mag(input logic [P-1:0][3:0] v);
        int s = 0;
        for (int i = 0; i < P; i++) s += int'(v[i]);
        return 16'(s);
    endfunction

    // mlp stubs: combinational sum, and the same sum behind three register stages
    assign mlp_out0 = sum_mag(mag0);
    always @(posedge clk) begin
        pipe1 <= sum_mag(mag1);
        pipe2 <= pipe1;
        pipe3 <= pipe2;
    end
    assign mlp_out1 = pipe3;

    always_comb begin
        s_ready[0] = s_ready0;  s_ready[1] = s_ready1;
        m_valid[0] = m_valid0;  m_valid[1] = m_valid1;
        m_err[0]   = m_err0;    m_err[1]   = m_err1;
        m_score[0] = m_score0;  m_score[1] = m_score1;
        mlp_mag[0] = mag0;      mlp_mag[1] = mag1;
        mlp_pol[0] = pol0;      mlp_pol[1] = pol1;
    end

    mlp_patch_loader #(.N1(98), .W_X(4), .W_Y(16), .MLP_LAT(0)) dut0 (
        .clk(clk), .rst(rst[0]), .s_valid(s_valid[0]), .s_ready(s_ready0),
        .s_mag(s_mag[0]), .s_pol(s_pol[0]), .s_last(s_last[0]),
        .mlp_in_mag(mag0), .mlp_in_pol(pol0), .mlp_out(mlp_out0),
        .m_valid(m_valid0), .m_ready(m_ready[0]), .m_score(m_score0), .m_err(m_err0)
    );

    mlp_patch_loader #(.N1(98), .W_X(4), .W_Y(16), .MLP_LAT(3)) dut3 (
        .clk(clk), .rst(rst[1]), .s_valid(s_valid[1]), .s_ready(s_ready1),
        .s_mag(s_mag[1]), .s_pol(s_pol[1]), .s_last(s_last[1]),
        .mlp_in_mag(mag1), .mlp_in_pol(pol1), .mlp_out(mlp_out1),
        .m_valid(m_valid1), .m_ready(m_ready[1]), .m_score(m_score1), .m_err(m_err1)
    );

    // Event monitors: m_err pulses, m_valid rising edges, and any m_err/m_valid overlap
    int ecnt[2];
    int vcnt[2];
    int overlap;
    logic vprev[2];
    initial begin
        ecnt[0] = 0; ecnt[1] = 0; vcnt[0] = 0; vcnt[1] = 0; overlap = 0;
        vprev[0] = 1'b0; vprev[1] = 1'b0;
    end
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (m_err[d] === 1'b1) ecnt[d]++;
            if (m_valid[d] === 1'b1 && !vprev[d]) vcnt[d]++;
            if (m_err[d] === 1'b1 && m_valid[d] === 1'b1) overlap++;
            vprev[d] = m_valid[d];
        end
    end

    // Reference model: what the parallel vector and framing errors should be, from the patch rules
    logic [P-1:0][3:0] em[2];
    logic [P-1:0]      ep[2];
    int                cnt[2];
    int                draining[2];
    int                exp_err[2];
    logic [15:0]       exp_sum[2];

    function automatic void model_reset(input int d);
        em[d] = '0; ep[d] = '0; cnt[d] = 0; draining[d] = 0;
    endfunction

    function automatic void model_accept(input int d, input logic [3:0] mag, input logic pol, input logic last);
        if (draining[d] == 0) begin
            em[d][cnt[d]] = mag;
            ep[d][cnt[d]] = pol;
            cnt[d]++;
            if (cnt[d] == P) begin
                cnt[d] = 0;
                if (last) begin
                    exp_sum[d] = 16'd0;
                    for (int i = 0; i < P; i++) exp_sum[d] = exp_sum[d] + 16'(em[d][i]);
                end else begin
                    exp_err[d]++;
                    draining[d] = 1;
                end
            end else if (last) begin
                exp_err[d]++;
                cnt[d] = 0;
            end
        end else if (last) begin
            draining[d] = 0;
        end
    endfunction

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One sample transfer; returns just after the accepting posedge
    task automatic xfer(input int d, input logic [3:0] mag, input logic pol, input logic last, input int gap);
        int n;
        if (gap != 0) begin
            while ($urandom_range(1, 0) == 1) @(negedge clk);
        end
        @(negedge clk);
        s_valid[d] = 1'b1; s_mag[d] = mag; s_pol[d] = pol; s_last[d] = last;
        n = 0;
        while (s_ready[d] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("s_ready_timeout", 256'(0), 256'(1));
        @(posedge clk);
        #1;
        s_valid[d] = 1'b0;
        model_accept(d, mag, pol, last);
    endtask

    // Send n samples; pattern 0 is mag=k%16/pol=k%2, otherwise random
    task automatic send_patch(input int d, input int n, input int with_last, input int pattern, input int gap);
        logic [3:0] mg;
        logic       pl;
        for (int k = 0; k < n; k++) begin
            if (pattern == 0) begin
                mg = 4'(k % 16); pl = 1'(k % 2);
            end else begin
                mg = 4'($urandom); pl = 1'($urandom);
            end
            xfer(d, mg, pl, (with_last != 0) && (k == n - 1), gap);
        end
    endtask

    task automatic wait_valid(input int d, input int exp_k, input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (m_valid[d] !== 1'b1 && k < 60);
        check(tag, 256'(k), 256'(exp_k));
    endtask

    task automatic consume(input int d, input string tag);
        @(negedge clk);
        m_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        m_ready[d] = 1'b0;
        @(negedge clk);
        check({tag, "_vld_drop"}, 256'(m_valid[d]), 256'(0));
        check({tag, "_s_ready"}, 256'(s_ready[d]), 256'(1));
    endtask

    task automatic check_vec(input int d, input string tag);
        check({tag, "_mag"}, 256'(mlp_mag[d]), 256'(em[d]));
        check({tag, "_pol"}, 256'(mlp_pol[d]), 256'(ep[d]));
    endtask

    task automatic pulse_reset(input int d);
        @(negedge clk);
        rst[d] = 1'b1;
        @(negedge clk);
        rst[d] = 1'b0;
        model_reset(d);
    endtask

    int e0, v0;
    logic [15:0] held;
    logic [P-1:0][3:0] gapfree_mag;
    logic [P-1:0]      gapfree_pol;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; s_valid[d] = 1'b0; s_mag[d] = '0; s_pol[d] = 1'b0;
            s_last[d] = 1'b0; m_ready[d] = 1'b0; exp_err[d] = 0; exp_sum[d] = '0;
            model_reset(d);
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_s_ready", 256'(s_ready[d]), 256'(0));
            check("rst_m_valid", 256'(m_valid[d]), 256'(0));
            check("rst_m_score", 256'(m_score[d]), 256'(0));
            check("rst_m_err", 256'(m_err[d]), 256'(0));
            check_vec(d, "rst");
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready0", 256'(s_ready[0]), 256'(1));
        check("post_rst_s_ready1", 256'(s_ready[1]), 256'(1));

        // Full patch, zero latency, known pattern
        send_patch(0, P, 1, 0, 0);
        check_vec(0, "full0");
        gapfree_mag = mlp_mag[0];
        gapfree_pol = mlp_pol[0];
        wait_valid(0, 2, "full0_latency");
        check("full0_score", 256'(m_score[0]), 256'(16'h0168));
        check("full0_model", 256'(m_score[0]), 256'(exp_sum[0]));
        consume(0, "full0");

        // Three-stage mlp, score stalled downstream
        send_patch(1, P, 1, 1, 0);
        check_vec(1, "lat3");
        wait_valid(1, 5, "lat3_latency");
        check("lat3_score", 256'(m_score[1]), 256'(exp_sum[1]));
        held = m_score[1];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("lat3_stall_score", 256'(m_score[1]), 256'(held));
            check("lat3_stall_s_ready", 256'(s_ready[1]), 256'(0));
            check("lat3_stall_vld", 256'(m_valid[1]), 256'(1));
        end
        consume(1, "lat3");

        // Short patch followed by a good one
        e0 = ecnt[0]; v0 = vcnt[0];
        send_patch(0, 20, 1, 1, 0);
        repeat (3) @(negedge clk);
        check("short_err", 256'(ecnt[0] - e0), 256'(1));
        check("short_no_vld", 256'(vcnt[0] - v0), 256'(0));
        send_patch(0, P, 1, 1, 0);
        check_vec(0, "short_next");
        wait_valid(0, 2, "short_next_latency");
        check("short_next_score", 256'(m_score[0]), 256'(exp_sum[0]));
        consume(0, "short_next");

        // Long patch: error after element 49, remainder drained
        e0 = ecnt[0]; v0 = vcnt[0];
        send_patch(0, 55, 1, 1, 0);
        repeat (3) @(negedge clk);
        check("long_err", 256'(ecnt[0] - e0), 256'(1));
        check("long_no_vld", 256'(vcnt[0] - v0), 256'(0));
        check_vec(0, "long_kept");
        send_patch(0, P, 1, 1, 0);
        wait_valid(0, 2, "long_next_latency");
        check("long_next_score", 256'(m_score[0]), 256'(exp_sum[0]));
        consume(0, "long_next");

        // Known pattern again with random valid gaps
        send_patch(0, P, 1, 0, 1);
        check("gap_mag", 256'(mlp_mag[0]), 256'(gapfree_mag));
        check("gap_pol", 256'(mlp_pol[0]), 256'(gapfree_pol));
        wait_valid(0, 2, "gap_latency");
        check("gap_score", 256'(m_score[0]), 256'(16'h0168));
        consume(0, "gap");

        // Reset while waiting on the pipelined mlp
        e0 = ecnt[1]; v0 = vcnt[1];
        send_patch(1, P, 1, 1, 0);
        pulse_reset(1);
        check("rstwait_vld", 256'(m_valid[1]), 256'(0));
        check("rstwait_score", 256'(m_score[1]), 256'(0));
        check_vec(1, "rstwait");
        repeat (6) @(negedge clk);
        check("rstwait_no_err", 256'(ecnt[1] - e0), 256'(0));
        check("rstwait_no_vld", 256'(vcnt[1] - v0), 256'(0));

        // Reset while holding a score
        e0 = ecnt[0];
        send_patch(0, P, 1, 1, 0);
        wait_valid(0, 2, "rstout_latency");
        pulse_reset(0);
        check("rstout_vld", 256'(m_valid[0]), 256'(0));
        check("rstout_score", 256'(m_score[0]), 256'(0));
        check_vec(0, "rstout");
        check("rstout_no_err", 256'(ecnt[0] - e0), 256'(0));

        // Fresh patches after reset
        for (int d = 0; d < 2; d++) begin
            send_patch(d, P, 1, 1, 1);
            check_vec(d, "fresh");
            wait_valid(d, (d == 0) ? 2 : 5, "fresh_latency");
            check("fresh_score", 256'(m_score[d]), 256'(exp_sum[d]));
            consume(d, "fresh");
        end

        check("err_total0", 256'(ecnt[0]), 256'(exp_err[0]));
        check("err_total1", 256'(ecnt[1]), 256'(exp_err[1]));
        check("err_vld_overlap", 256'(overlap), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
